// File: rtl/bcd_to_bin_if.sv
// bcd_to_bin_if: request/result handshake bundle for bcd_to_bin.
// BCD_TO_BIN_SIGNED_EN adds the in_neg request field.
interface bcd_to_bin_if #(
  parameter int DIGITS   = 4,
  parameter int OUT_BITS = 16
);

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_bcd;
`ifdef BCD_TO_BIN_SIGNED_EN
  logic                  in_neg;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_BITS-1:0]   out_data;
  logic                  out_err;

  modport master (
    output in_valid,
    input  in_ready,
    output in_bcd,
`ifdef BCD_TO_BIN_SIGNED_EN
    output in_neg,
`endif
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_err
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_bcd,
`ifdef BCD_TO_BIN_SIGNED_EN
    input  in_neg,
`endif
    output out_valid,
    input  out_ready,
    output out_data,
    output out_err
  );

endinterface

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: packed BCD to binary, one digit per clock, MSD first.
// Optional BCD_TO_BIN_SIGNED_EN: in_neg negates the result.
module bcd_to_bin #(
  parameter int DIGITS   = 4,
  parameter int OUT_BITS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  bcd_to_bin_if.slave bus
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic [SW-1:0]       sreg_q;
  logic [OUT_BITS-1:0] acc_q;
  logic [CW-1:0]       cnt_q;
  logic                err_q;
  logic [OUT_BITS-1:0] data_q;
  logic                oerr_q;
`ifdef BCD_TO_BIN_SIGNED_EN
  logic                neg_q;
`endif

  logic                accept;
  logic                last;
  logic [3:0]          dig;
  logic                bad;
  logic [3:0]          dig_ok;
  logic [OUT_BITS-1:0] acc_nx;
  logic                err_nx;
  logic [OUT_BITS-1:0] res;
  logic [OUT_BITS-1:0] data_d;

  assign accept = bus.in_valid && (state_q == IDLE);
  assign last   = (cnt_q == CW'(DIGITS - 1));

  // Digit step: fold the top nibble, drop invalid nibbles from value.
  always_comb begin
    dig    = sreg_q[SW-1 -: 4];
    bad    = (dig > 4'd9);
    dig_ok = bad ? 4'd0 : dig;
    acc_nx = (acc_q << 3) + (acc_q << 1)
           + OUT_BITS'(dig_ok);
    err_nx = err_q | bad;
`ifdef BCD_TO_BIN_SIGNED_EN
    res    = neg_q ? (~acc_nx + 1'b1) : acc_nx;
`else
    res    = acc_nx;
`endif
    data_d = err_nx ? '0 : res;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): if (bus.in_valid) state_d = CONV;
      (state_q == CONV): if (last)         state_d = DONE;
      (state_q == DONE): if (bus.out_ready) state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state alone.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.out_data  = data_q;
    bus.out_err   = oerr_q;
  end

  // Shift register, accumulator and result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      data_q <= '0;
      oerr_q <= 1'b0;
`ifdef BCD_TO_BIN_SIGNED_EN
      neg_q  <= 1'b0;
`endif
    end else if (accept) begin
      sreg_q <= bus.in_bcd;
      acc_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
`ifdef BCD_TO_BIN_SIGNED_EN
      neg_q  <= bus.in_neg;
`endif
    end else if (state_q == CONV) begin
      sreg_q <= sreg_q << 4;
      acc_q  <= acc_nx;
      cnt_q  <= cnt_q + 1'b1;
      err_q  <= err_nx;
      if (last) begin
        data_q <= data_d;
        oerr_q <= err_nx;
      end
    end
  end

endmodule
